// File: rtl/term_cursor_ctrl.sv
// term_cursor_ctrl: sole writer of the character screen RAM for the text
// terminal. It turns keyboard commands into cell writes and moves the cursor.
// It also handles line wrap, scrolling with row clearing, the power-up screen
// clear and the blinking cursor glyph.
module term_cursor_ctrl #(
  parameter int          COLS         = 70,
  parameter int          ROWS         = 30,
  parameter int          COL_W        = 7,
  parameter int          ROW_W        = 5,
  parameter int          BLINK_CYCLES = 25000000,
  parameter logic [7:0]  CURSOR_CHAR  = 8'h0B
) (
  input  logic             CLOCK_50,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_kind,
  input  logic [7:0]       in_code,
  output logic             wr_en,
  output logic [ROW_W-1:0] wr_row,
  output logic [COL_W-1:0] wr_col,
  output logic [7:0]       wr_data,
  output logic [ROW_W-1:0] cur_row,
  output logic [COL_W-1:0] cur_col,
  output logic [ROW_W-1:0] scroll_top,
  output logic             busy
);

  localparam int LEN_W = COL_W + 1;
  localparam int BW    = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

  localparam logic [COL_W-1:0] LAST_COL   = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] LAST_ROW   = ROW_W'(ROWS - 1);
  localparam logic [BW-1:0]    BLINK_LAST = BW'(BLINK_CYCLES - 1);
  localparam logic [LEN_W-1:0] LEN_FULL   = LEN_W'(COLS);

  localparam logic [1:0] K_PRINT = 2'd0;
  localparam logic [1:0] K_BKSP  = 2'd1;
  localparam logic [1:0] K_ENTER = 2'd2;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    EXEC,
    CLEAR,
    DRAW
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic [ROW_W-1:0] r_cur_row;
  logic [COL_W-1:0] r_cur_col;
  logic [ROW_W-1:0] r_scroll_top;
  logic [ROW_W-1:0] r_fill_row;
  logic [COL_W-1:0] r_fill_col;
  logic             r_blink_on;
  logic [BW-1:0]    r_blink_cnt;
  logic [LEN_W-1:0] r_line_len [ROWS];
  logic [1:0]       r_cmd_kind;
  logic [7:0]       r_cmd_code;

  logic [ROW_W-1:0] w_row_inc;
  logic [ROW_W-1:0] w_row_dec;
  logic [ROW_W-1:0] w_top_inc;
  logic [LEN_W-1:0] w_prev_len;
  logic             w_blink_tick;
  logic             w_accept;

  logic             w_exec_wr;
  logic [7:0]       w_exec_data;
  logic [ROW_W-1:0] w_new_row;
  logic [COL_W-1:0] w_new_col;
  logic [ROW_W-1:0] w_new_top;
  logic             w_newline;
  logic             w_scroll;
  logic             w_len_a_we;
  logic [LEN_W-1:0] w_len_a_val;
  logic             w_len_b_we;
  logic [ROW_W-1:0] w_len_b_idx;
  logic [LEN_W-1:0] w_len_b_val;

  logic             w_wr_en;
  logic [ROW_W-1:0] w_wr_row;
  logic [COL_W-1:0] w_wr_col;
  logic [7:0]       w_wr_data;
  logic             w_in_ready;

  assign w_row_inc    = (r_cur_row == LAST_ROW) ? '0 : r_cur_row + ROW_W'(1);
  assign w_row_dec    = (r_cur_row == '0) ? LAST_ROW : r_cur_row - ROW_W'(1);
  assign w_top_inc    = (r_scroll_top == LAST_ROW) ? '0 : r_scroll_top + ROW_W'(1);
  assign w_prev_len   = r_line_len[w_row_dec];
  assign w_blink_tick = (r_state == IDLE) && (r_blink_cnt == BLINK_LAST);
  assign w_accept     = (r_state == IDLE) && in_valid && w_in_ready;

  // Decode the latched command against the old cursor: cell write, new cursor, line lengths, scroll.
  always_comb begin
    w_exec_wr   = 1'b0;
    w_exec_data = 8'h00;
    w_new_row   = r_cur_row;
    w_new_col   = r_cur_col;
    w_new_top   = r_scroll_top;
    w_newline   = 1'b0;
    w_scroll    = 1'b0;
    w_len_a_we  = 1'b0;
    w_len_a_val = '0;
    w_len_b_we  = 1'b0;
    w_len_b_idx = w_row_inc;
    w_len_b_val = '0;

    case (r_cmd_kind)
      K_PRINT: begin
        w_exec_wr   = 1'b1;
        w_exec_data = r_cmd_code;
        w_len_a_we  = 1'b1;
        w_len_a_val = LEN_W'(r_cur_col) + LEN_W'(1);
        if (r_cur_col == LAST_COL) begin
          w_newline = 1'b1;
        end else begin
          w_new_col = r_cur_col + COL_W'(1);
        end
      end
      K_BKSP: begin
        if (r_cur_col != '0) begin
          w_exec_wr   = 1'b1;
          w_new_col   = r_cur_col - COL_W'(1);
          w_len_a_we  = 1'b1;
          w_len_a_val = LEN_W'(r_cur_col) - LEN_W'(1);
        end else if (r_cur_row != r_scroll_top) begin
          w_exec_wr = 1'b1;
          w_new_row = w_row_dec;
          if (w_prev_len < LEN_FULL) begin
            w_new_col = w_prev_len[COL_W-1:0];
          end else begin
            w_new_col   = LAST_COL;
            w_len_b_we  = 1'b1;
            w_len_b_idx = w_row_dec;
            w_len_b_val = LEN_W'(LAST_COL);
          end
        end
      end
      K_ENTER: begin
        w_exec_wr   = 1'b1;
        w_len_a_we  = 1'b1;
        w_len_a_val = LEN_W'(r_cur_col);
        w_newline   = 1'b1;
      end
      default: begin
      end
    endcase

    if (w_newline) begin
      w_new_row   = w_row_inc;
      w_new_col   = '0;
      w_len_b_we  = 1'b1;
      w_len_b_idx = w_row_inc;
      w_len_b_val = '0;
      if (w_row_inc == r_scroll_top) begin
        w_new_top = w_top_inc;
        w_scroll  = 1'b1;
      end
    end
  end

  // Next state and the single screen-RAM write port, chosen by the current state.
  always_comb begin
    w_next_state = r_state;
    w_wr_en      = 1'b0;
    w_wr_row     = r_cur_row;
    w_wr_col     = r_cur_col;
    w_wr_data    = 8'h00;
    w_in_ready   = 1'b0;

    case (r_state)
      INIT: begin
        w_wr_en  = 1'b1;
        w_wr_row = r_fill_row;
        w_wr_col = r_fill_col;
        if ((r_fill_row == LAST_ROW) && (r_fill_col == LAST_COL)) begin
          w_next_state = DRAW;
        end
      end
      IDLE: begin
        w_in_ready = !w_blink_tick;
        if (w_blink_tick) begin
          w_wr_en   = 1'b1;
          w_wr_data = r_blink_on ? 8'h00 : CURSOR_CHAR;
        end
        if (in_valid && !w_blink_tick) begin
          w_next_state = EXEC;
        end
      end
      EXEC: begin
        w_wr_en      = w_exec_wr;
        w_wr_data    = w_exec_data;
        w_next_state = w_scroll ? CLEAR : DRAW;
      end
      CLEAR: begin
        w_wr_en  = 1'b1;
        w_wr_col = r_fill_col;
        if (r_fill_col == LAST_COL) begin
          w_next_state = DRAW;
        end
      end
      DRAW: begin
        w_wr_en      = 1'b1;
        w_wr_data    = CURSOR_CHAR;
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = INIT;
      end
    endcase
  end

  // State register; reset restarts the power-up clear.
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= INIT;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Hold the accepted command for the EXEC cycle.
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      r_cmd_kind <= 2'd0;
      r_cmd_code <= 8'h00;
    end else if (w_accept) begin
      r_cmd_kind <= in_kind;
      r_cmd_code <= in_code;
    end
  end

  // The cursor and display top move only at the end of EXEC.
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      r_cur_row    <= '0;
      r_cur_col    <= '0;
      r_scroll_top <= '0;
    end else if (r_state == EXEC) begin
      r_cur_row    <= w_new_row;
      r_cur_col    <= w_new_col;
      r_scroll_top <= w_new_top;
    end
  end

  // Cell walker: row-major over the whole screen in INIT, along one row in CLEAR.
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      r_fill_row <= '0;
      r_fill_col <= '0;
    end else if (r_state == INIT) begin
      if (r_fill_col == LAST_COL) begin
        r_fill_col <= '0;
        r_fill_row <= (r_fill_row == LAST_ROW) ? '0 : r_fill_row + ROW_W'(1);
      end else begin
        r_fill_col <= r_fill_col + COL_W'(1);
      end
    end else if (r_state == CLEAR) begin
      r_fill_row <= '0;
      r_fill_col <= (r_fill_col == LAST_COL) ? '0 : r_fill_col + COL_W'(1);
    end else begin
      r_fill_row <= '0;
      r_fill_col <= '0;
    end
  end

  // Blink timer: counts idle cycles, toggles the phase on each tick, restarts ON after every redraw.
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      r_blink_on  <= 1'b1;
      r_blink_cnt <= '0;
    end else if (r_state == DRAW) begin
      r_blink_on  <= 1'b1;
      r_blink_cnt <= '0;
    end else if (r_state == IDLE) begin
      if (w_blink_tick) begin
        r_blink_on  <= ~r_blink_on;
        r_blink_cnt <= '0;
      end else begin
        r_blink_cnt <= r_blink_cnt + BW'(1);
      end
    end
  end

  // Per-row character counts; the new-row update is applied after the current-row one.
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ROWS; i++) begin
        r_line_len[i] <= '0;
      end
    end else if (r_state == EXEC) begin
      if (w_len_a_we) begin
        r_line_len[r_cur_row] <= w_len_a_val;
      end
      if (w_len_b_we) begin
        r_line_len[w_len_b_idx] <= w_len_b_val;
      end
    end
  end

  assign wr_en      = w_wr_en & rst_n;
  assign wr_row     = w_wr_row;
  assign wr_col     = w_wr_col;
  assign wr_data    = w_wr_data;
  assign in_ready   = w_in_ready;
  assign cur_row    = r_cur_row;
  assign cur_col    = r_cur_col;
  assign scroll_top = r_scroll_top;
  assign busy       = (r_state != IDLE);

endmodule
